// File: rtl/fir_serial_mac_2bank.sv
// Time-multiplexed FIR filter: a single multiplier-accumulator walks all TAPS
// coefficients per sample, reading from one of two runtime-loadable banks.
module fir_serial_mac_2bank #(
  parameter int TAPS      = 51,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_SHIFT = 0,
  parameter int OUT_W     = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     bank_sel,
  input  logic                     coef_we,
  input  logic                     coef_bank,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_err,
  output logic                     m_valid,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     sat_flag,
  output logic                     busy
);

  localparam int AW  = $clog2(TAPS);
  localparam int AW1 = AW + 1;
  localparam int PW  = DATA_W + COEF_W;
  // Working width for rounding/clipping: one guard bit over whichever is wider.
  localparam int SW  = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W + 1;

  localparam logic [AW-1:0]        LAST   = AW'(TAPS - 1);
  localparam logic [AW:0]          TAPS_L = AW1'(TAPS);
  localparam logic signed [SW-1:0] RND    =
    (OUT_SHIFT > 0) ? (SW'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;
  localparam logic signed [SW-1:0] OMAX   = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] OMIN   = ~OMAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state, state_nx;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef  [2][TAPS];
  logic [AW-1:0]            wr_ptr, rd_ptr, k;
  logic                     act_bank;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] x_rd;
  logic signed [COEF_W-1:0] h_rd;
  logic signed [PW-1:0]     prod;
  logic [OUT_W:0]           sat_res;
  logic                     accept, addr_bad, bank_locked;

  function automatic logic signed [SW-1:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [SW-1:0] e;
    e = SW'(a);
    round_shift = (e + RND) >>> OUT_SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [SW-1:0] r);
    if (r > OMAX)      saturate = {1'b1, OMAX[OUT_W-1:0]};
    else if (r < OMIN) saturate = {1'b1, OMIN[OUT_W-1:0]};
    else               saturate = {1'b0, r[OUT_W-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nx = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k == LAST) state_nx = OUT;
      end
      OUT: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept      = s_valid & s_ready;
  assign addr_bad    = {1'b0, coef_addr} >= TAPS_L;
  assign bank_locked = busy && (coef_bank == act_bank);

  // Coefficient banks: the bank feeding the current pass is frozen while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_err <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < TAPS; t++)
          coef[b][t] <= '0;
    end else begin
      coef_err <= coef_we & (addr_bad | bank_locked);
      if (coef_we && !addr_bad && !bank_locked)
        coef[coef_bank][coef_addr] <= coef_wdata;
    end
  end

  // MAC stage: x[n-k] walks backwards from the newest sample.
  assign x_rd = dline[rd_ptr];
  assign h_rd = coef[act_bank][k];
  assign prod = PW'(x_rd) * PW'(h_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < TAPS; t++) dline[t] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      k        <= '0;
      act_bank <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dline[wr_ptr] <= s_data;
          rd_ptr        <= wr_ptr;
          act_bank      <= bank_sel;
          acc           <= '0;
          k             <= '0;
        end
        MAC: begin
          acc    <= acc + ACC_W'(prod);
          k      <= (k == LAST) ? '0 : k + 1'b1;
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
          if (k == LAST) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output stage: round half up, shift, clip to OUT_W.
  assign sat_res = saturate(round_shift(acc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      sat_flag <= 1'b0;
    end else begin
      m_valid <= (state == OUT);
      if (state == OUT) begin
        m_data   <= sat_res[OUT_W-1:0];
        sat_flag <= sat_res[OUT_W];
      end
    end
  end

endmodule

// File: tb/tb_fir_serial_mac_2bank.sv
// Bench for fir_serial_mac_2bank: a full-width instance and a shifted/clipping
// instance share all inputs and are checked against a sum-of-products model.
`timescale 1ns/1ps
module tb_fir_serial_mac_2bank;
  localparam int TAPS = 51, DATA_W = 16, COEF_W = 16, AW = $clog2(TAPS);
  localparam int OW_A = 38, SH_A = 0, OW_B = 16, SH_B = 15;

  logic clk = 1'b0, rst_n = 1'b1;
  logic s_valid = 1'b0, bank_sel = 1'b0, coef_we = 1'b0, coef_bank = 1'b0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic s_ready_a, coef_err_a, m_valid_a, sat_a, busy_a;
  logic s_ready_b, coef_err_b, m_valid_b, sat_b, busy_b;
  logic signed [OW_A-1:0] m_data_a;
  logic signed [OW_B-1:0] m_data_b;

  fir_serial_mac_2bank #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .OUT_SHIFT(SH_A), .OUT_W(OW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .bank_sel(bank_sel), .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err_a), .m_valid(m_valid_a), .m_data(m_data_a),
    .sat_flag(sat_a), .busy(busy_a));

  fir_serial_mac_2bank #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .OUT_SHIFT(SH_B), .OUT_W(OW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .bank_sel(bank_sel), .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err_b), .m_valid(m_valid_b), .m_data(m_data_b),
    .sat_flag(sat_b), .busy(busy_b));

  always #5 clk = ~clk;

  int cycnt = 0;
  always @(posedge clk) cycnt <= cycnt + 1;

  typedef struct { longint d_a; longint s_a; longint d_b; longint s_b; } exp_t;
  longint coef_m [2][TAPS];
  longint hist[$];
  exp_t   expq[$];
  int     n_cmp = 0, n_bad = 0, acc_cyc = 0;
  longint last_a = 0, last_b = 0, last_sb = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void scale(input longint acc, input int sh, input int w,
                                output longint d, output longint s);
    longint r, mx, mn;
    r = acc;
    if (sh > 0) r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (r > mx)      begin d = mx; s = 1; end
    else if (r < mn) begin d = mn; s = 1; end
    else             begin d = r;  s = 0; end
  endfunction

  function automatic void model_accept(input longint x, input bit b);
    exp_t e;
    longint acc = 0;
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    foreach (hist[i]) acc += coef_m[b][i] * hist[i];
    scale(acc, SH_A, OW_A, e.d_a, e.s_a);
    scale(acc, SH_B, OW_B, e.d_b, e.s_b);
    expq.push_back(e);
  endfunction

  function automatic void clear_model();
    hist.delete();
    expq.delete();
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < TAPS; t++) coef_m[b][t] = 0;
  endfunction

  task automatic wr(input bit b, input int addr, input longint d, input bit exp_err);
    @(negedge clk);
    coef_we = 1'b1; coef_bank = b; coef_addr = AW'(addr); coef_wdata = COEF_W'(d);
    @(posedge clk);
    #1 coef_we = 1'b0;
    @(negedge clk);
    chk("coef_err", coef_err_a, exp_err);
    if (exp_err) begin
      @(negedge clk);
      chk("coef_err_pulse_end", coef_err_a, 0);
    end else coef_m[b][addr] = d;
  endtask

  task automatic accept(input longint x, input bit b);
    @(negedge clk);
    chk("s_ready_idle", s_ready_a, 1);
    s_valid = 1'b1; s_data = DATA_W'(x); bank_sel = b;
    @(posedge clk);
    #1 s_valid = 1'b0;
    acc_cyc = cycnt;
    model_accept(x, b);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (expq.size() == 0) begin
      chk({tag, "_unexpected_valid"}, m_valid_a, 0);
      return;
    end
    e = expq.pop_front();
    chk({tag, "_data_a"}, m_data_a, e.d_a);
    chk({tag, "_sat_a"}, sat_a, e.s_a);
    chk({tag, "_valid_b"}, m_valid_b, 1);
    chk({tag, "_data_b"}, m_data_b, e.d_b);
    chk({tag, "_sat_b"}, sat_b, e.s_b);
    last_a = m_data_a; last_b = m_data_b; last_sb = sat_b;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (m_valid_a !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (m_valid_a !== 1'b1) begin
      chk({tag, "_timeout"}, m_valid_a, 1);
      void'(expq.pop_front());
      return;
    end
    chk({tag, "_latency"}, cycnt - acc_cyc + 1, TAPS + 2);
    chk({tag, "_ready_with_valid"}, s_ready_a, 1);
    check_out(tag);
    @(negedge clk);
    chk({tag, "_valid_pulse"}, m_valid_a, 0);
  endtask

  task automatic sample(input longint x, input bit b, input string tag);
    accept(x, b);
    wait_out(tag);
  endtask

  task automatic impulse();
    for (int i = 0; i < 61; i++) begin
      sample((i == 0) ? 1 : 0, 1'b0, "impulse");
      chk("impulse_value", last_a, (i < TAPS) ? i + 1 : 0);
    end
  endtask

  function automatic longint rnd16();
    return longint'(int'($urandom_range(0, 65535)) - 32768);
  endfunction

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready_a, 1);
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_m_data", m_data_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_coef_err", coef_err_a, 0);
    rst_n = 1'b1;
    clear_model();

    // impulse response with h[k]=k+1
    for (int t = 0; t < TAPS; t++) wr(0, t, t + 1, 0);
    impulse();

    // bank switching
    for (int t = 0; t < TAPS; t++) wr(0, t, 1, 0);
    wr(1, 0, -1, 0);
    for (int i = 0; i < TAPS; i++) sample(100, 1'b0, "bank_fill");
    for (int i = 0; i < 10; i++) begin
      sample(100, (i % 2) == 0, "bank_alt");
      chk("bank_alt_value", last_a, ((i % 2) == 0) ? -100 : 5100);
    end

    // random coefficients and samples
    for (int b = 0; b < 2; b++)
      for (int t = 0; t < TAPS; t++) wr(b, t, rnd16(), 0);
    for (int i = 0; i < 20; i++) sample(rnd16(), 1'($urandom_range(0, 1)), "random");

    // saturation at full scale
    for (int t = 0; t < TAPS; t++) wr(0, t, 32767, 0);
    for (int i = 0; i < TAPS + 4; i++) sample(32767, 1'b0, "sat_pos");
    chk("sat_full_b", last_b, 32767);
    chk("sat_flag_b", last_sb, 1);
    chk("sat_full_a", last_a, longint'(TAPS) * 32767 * 32767);
    for (int i = 0; i < 3; i++) sample(-32768, 1'b0, "sat_neg");

    // continuous s_valid with incrementing data
    begin
      int cyc = 0, nacc = 0, last = 0, low = 0, nout = 0;
      longint v = 200;
      @(negedge clk);
      s_valid = 1'b1; s_data = DATA_W'(v); bank_sel = 1'b0;
      while (nacc < 5 && cyc < 400) begin
        if (m_valid_a === 1'b1) begin
          check_out("hs");
          nout++;
        end
        if (s_ready_a === 1'b1) begin
          if (nacc > 0) begin
            chk("hs_accept_period", cyc - last, TAPS + 2);
            chk("hs_ready_low", low, TAPS + 1);
          end
          last = cyc; low = 0; nacc++;
          model_accept(v, 1'b0);
          @(posedge clk);
          #1 acc_cyc = cycnt;
          v++;
          s_data = DATA_W'(v);
          if (nacc == 5) s_valid = 1'b0;
        end else low++;
        @(negedge clk);
        cyc++;
      end
      chk("hs_accepts", nacc, 5);
      chk("hs_outputs_before_drain", nout, 4);
      wait_out("hs_last");
    end

    // write protection during MAC
    accept(1000, 1'b0);
    wr(0, 3, 999, 1);
    wr(1, 5, 77, 0);
    wr(0, 51, 5, 1);
    chk("wp_busy_still", busy_a, 1);
    wait_out("wp_out");
    sample(500, 1'b1, "wp_other_bank");

    // coefficient write and sample acceptance on the same edge
    @(negedge clk);
    coef_we = 1'b1; coef_bank = 1'b0; coef_addr = '0; coef_wdata = -16'sd5;
    s_valid = 1'b1; s_data = 16'sd300; bank_sel = 1'b0;
    @(posedge clk);
    #1 coef_we = 1'b0; s_valid = 1'b0;
    acc_cyc = cycnt;
    coef_m[0][0] = -5;
    model_accept(300, 1'b0);
    @(negedge clk);
    chk("same_edge_coef_err", coef_err_a, 0);
    wait_out("same_edge");

    // reset in the middle of a MAC pass
    accept(4321, 1'b1);
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_ready", s_ready_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_m_valid", m_valid_a, 0);
    chk("midrst_m_data", m_data_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    begin
      int seen = 0;
      repeat (70) begin
        @(negedge clk);
        if (m_valid_a === 1'b1) seen++;
      end
      chk("midrst_no_valid", seen, 0);
      chk("midrst_m_data_hold", m_data_a, 0);
    end
    sample(12345, 1'b0, "cleared");
    chk("cleared_a", last_a, 0);
    chk("cleared_b", last_b, 0);

    // rounding: 16384 >> 15 rounds half up to 1
    wr(1, 0, 16384, 0);
    sample(1, 1'b1, "round");
    chk("round_b", last_b, 1);
    chk("round_a", last_a, 16384);
    for (int i = 0; i < TAPS; i++) sample(0, 1'b1, "flush");

    // reload and repeat the impulse response
    for (int t = 0; t < TAPS; t++) wr(0, t, t + 1, 0);
    impulse();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
